// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_port_arbiter : alternating fetch/data arbiter with fixed-latency
//                    single-port memory access sequencing
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_D   = 1'b1;
  localparam logic [3:0] LAT_M1  = 4'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_gnt_q <= OWN_IF;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    // On a tie the port that lost last time wins; otherwise whoever asks.
    grant      = (if_req && d_req) ? ~last_gnt_q : d_req;
    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          owner_d    = grant;
          last_gnt_d = grant;
          if (grant == OWN_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == OWN_D) d_rdata_d  = mem_rdata;
            else                  if_rdata_d = mem_rdata;
          end
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = (state_q == S_ACK) && (owner_q == OWN_IF);
    d_ack     = (state_q == S_ACK) && (owner_q == OWN_D);
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    busy      = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Directed self-checking bench for mem_port_arbiter (MEM_LAT 2, 1 and 15).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
  logic [15:0] if_addr, d_addr, mem_addr;
  logic [31:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Two-stage read pipeline: data appears exactly two cycles after mem_en.
  logic [31:0] mem [0:255];
  logic [31:0] pipe0, pipe1;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    pipe0 <= mem_en ? mem[mem_addr[7:0]] : 32'hBADBAD00;
    pipe1 <= pipe0;
  end
  assign mem_rdata = pipe1;

  // Latency-1 and latency-15 builds; read data is only correct in the exact cycle.
  logic        a_req, a_ack, a_dack, a_en, a_we, a_busy;
  logic [15:0] a_addr, a_maddr;
  logic [31:0] a_rdata, a_drdata, a_mwdata, a_mrd;
  logic [4:0]  a_age;
  logic        b_req, b_ack, b_dack, b_en, b_we, b_busy;
  logic [15:0] b_addr, b_maddr;
  logic [31:0] b_rdata, b_drdata, b_mwdata, b_mrd;
  logic [4:0]  b_age;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(a_req), .if_addr(a_addr), .if_ack(a_ack), .if_rdata(a_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(32'h0),
    .d_ack(a_dack), .d_rdata(a_drdata),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_rdata(a_mrd), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_req), .if_addr(b_addr), .if_ack(b_ack), .if_rdata(b_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(32'h0),
    .d_ack(b_dack), .d_rdata(b_drdata),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_rdata(b_mrd), .busy(b_busy)
  );

  always @(posedge clk) begin
    if (!rst_n)                         a_age <= 5'd0;
    else if (a_en)                      a_age <= 5'd1;
    else if (a_age != 0 && a_age != 31) a_age <= a_age + 5'd1;
    if (!rst_n)                         b_age <= 5'd0;
    else if (b_en)                      b_age <= 5'd1;
    else if (b_age != 0 && b_age != 31) b_age <= b_age + 5'd1;
  end
  assign a_mrd = (a_age == 5'd1)  ? 32'h1111_1111 : 32'hBAD0_0001;
  assign b_mrd = (b_age == 5'd15) ? 32'h1515_1515 : 32'hBAD0_0015;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({if_ack, d_ack, mem_en, mem_we, busy} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {if_ack, d_ack, mem_en, mem_we, busy});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 48'h0) begin
      n_bad++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata});
    end
    n_cmp++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (mem_en || busy || if_ack || d_ack) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL idle_activity: got %b expected 0", seen);
    end
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 16'h0004;
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 16'h0004, 1'b1}) begin
      n_bad++; $display("FAIL fetch_issue: got en=%b we=%b addr=%h busy=%b expected 1 0 0004 1",
                        mem_en, mem_we, mem_addr, busy);
    end
    tick();
    n_cmp++;
    if (mem_en !== 1'b0) begin
      n_bad++; $display("FAIL fetch_en_one_cycle: got %b expected 0", mem_en);
    end
    repeat (2) tick();
    n_cmp++;
    if ({if_ack, d_ack, if_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL fetch_ack: got ack=%b dack=%b data=%h expected 1 0 deadbeef",
                        if_ack, d_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
    n_cmp++;
    if ({if_ack, busy, if_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL fetch_done: got ack=%b busy=%b data=%h expected 0 0 deadbeef",
                        if_ack, busy, if_rdata);
    end
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 32'h1234_5678;
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0010, 32'h1234_5678}) begin
      n_bad++; $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h expected 1 1 0010 12345678",
                        mem_en, mem_we, mem_addr, mem_wdata);
    end
    repeat (3) tick();
    n_cmp++;
    if ({d_ack, if_ack, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL store_ack: got ack=%b iack=%b rdata=%h expected 1 0 00000000",
                        d_ack, if_ack, d_rdata);
    end
    d_we = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      n_bad++; $display("FAIL load_issue: got en=%b we=%b addr=%h expected 1 0 0010", mem_en, mem_we, mem_addr);
    end
    repeat (3) tick();
    n_cmp++;
    if ({d_ack, d_rdata} !== {1'b1, 32'h1234_5678}) begin
      n_bad++; $display("FAIL load_ack: got ack=%b rdata=%h expected 1 12345678", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] seq;
    int         nacks;
    logic       overlap, bad_data;
    rst_n = 1'b0;
    if_addr = 16'h0020; d_addr = 16'h0030; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    tick();
    rst_n = 1'b1;
    seq = 4'b0; nacks = 0; overlap = 1'b0; bad_data = 1'b0;
    for (int i = 0; i < 40 && nacks < 4; i++) begin
      tick();
      if (if_ack && d_ack) overlap = 1'b1;
      if (d_ack && d_rdata !== 32'hB0B0_B0B0) bad_data = 1'b1;
      if (if_ack && if_rdata !== 32'hA0A0_A0A0) bad_data = 1'b1;
      if (if_ack || d_ack) begin
        seq[nacks] = d_ack;
        nacks++;
        if (nacks == 4) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    n_cmp++;
    if (nacks != 4) begin
      n_bad++; $display("FAIL contention_count: got %0d expected 4", nacks);
    end
    n_cmp++;
    if (seq !== 4'b0101) begin
      n_bad++; $display("FAIL contention_order: got %b expected 0101 (d,f,d,f from bit0)", seq);
    end
    n_cmp++;
    if ({overlap, bad_data} !== 2'b00) begin
      n_bad++; $display("FAIL contention_ack_data: got overlap=%b bad=%b expected 0 0", overlap, bad_data);
    end
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL contention_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    if_req = 1'b1; if_addr = 16'h0040;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_en, busy} !== 2'b00) begin
      n_bad++; $display("FAIL midreset_abort: got en=%b busy=%b expected 0 0", mem_en, busy);
    end
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (if_ack || mem_en) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL midreset_no_ack: got %b expected 0", seen);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0040}) begin
      n_bad++; $display("FAIL midreset_replay_issue: got en=%b addr=%h expected 1 0040", mem_en, mem_addr);
    end
    repeat (3) tick();
    n_cmp++;
    if ({if_ack, if_rdata} !== {1'b1, 32'hC0FF_EE11}) begin
      n_bad++; $display("FAIL midreset_replay_ack: got ack=%b data=%h expected 1 c0ffee11", if_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_lat1();
    int  cyc;
    logic got;
    a_req = 1'b1; a_addr = 16'h0050;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      cyc++;
      if (a_ack) got = 1'b1;
    end
    n_cmp++;
    if (!got || cyc != 3) begin
      n_bad++; $display("FAIL lat1_ack_cycle: got %0d (seen=%b) expected 3", cyc, got);
    end
    n_cmp++;
    if (a_rdata !== 32'h1111_1111) begin
      n_bad++; $display("FAIL lat1_data: got %h expected 11111111", a_rdata);
    end
    a_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_lat15();
    int  cyc;
    logic got;
    b_req = 1'b1; b_addr = 16'h0060;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      cyc++;
      if (b_ack) got = 1'b1;
    end
    n_cmp++;
    if (!got || cyc != 17) begin
      n_bad++; $display("FAIL lat15_ack_cycle: got %0d (seen=%b) expected 17", cyc, got);
    end
    n_cmp++;
    if (b_rdata !== 32'h1515_1515) begin
      n_bad++; $display("FAIL lat15_data: got %h expected 15151515", b_rdata);
    end
    b_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 16'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 32'h0;
    a_req = 1'b0; a_addr = 16'h0; b_req = 1'b0; b_addr = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEAD_BEEF;
    mem[8'h20] = 32'hA0A0_A0A0;
    mem[8'h30] = 32'hB0B0_B0B0;
    mem[8'h40] = 32'hC0FF_EE11;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_reset_mid();
    test_lat1();
    test_lat15();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shared-memory arbiter and access sequencer for the multi-cycle CPU. The fetch stage (instruction reads) and the memory stage (data loads/stores) both use a single-port synchronous memory. This block accepts one request from each, grants them alternately when both are pending, and sequences each access through issue, fixed-latency wait and acknowledge. It sits between the CPU stage sequencer and the unified memory macro.

## Interface
- ADDR_W, 16, address width (matches PC width)
- DATA_W, 32, data/instruction width
- MEM_LAT, 2, cycles from mem_en issue to valid mem_rdata; legal range 1..15

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  DATA_W  fetched instruction, registered
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load data, registered
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  ADDR_W  memory address, valid with mem_en
- mem_wdata  out  DATA_W  memory write data, valid with mem_en
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: samples requests.
  - Only one req high: grant it.
  - Both high: grant the port not granted last (last_gnt register).
  - Neither high: stay in IDLE.
- On grant, at the edge leaving IDLE:
  - latch owner, addr, we (forced 0 for fetch) and wdata into internal registers;
  - set last_gnt = owner;
  - go to ISSUE.
- ISSUE: drive mem_en=1, mem_we, mem_addr and mem_wdata from the latched registers. Go to WAIT with the wait counter loaded to MEM_LAT-1.
- WAIT: lasts exactly MEM_LAT cycles; the counter decrements each cycle.
  - At the edge ending the last WAIT cycle, on a read, capture mem_rdata into if_rdata or d_rdata per owner.
  - Stores do not update d_rdata.
  - Then go to ACK.
- ACK: pulse the owner's ack for one cycle, then go to IDLE.
  - Requests are not sampled in ACK, so the acked requester's still-high req is never re-served.
  - A requester wanting back-to-back access keeps req high past ACK; it is sampled in the following IDLE.
- mem_en/mem_we are 0 outside ISSUE. mem_addr/mem_wdata hold their latched values.
- if_rdata/d_rdata hold their value until the next completed read on that port.
- Request-input changes while a port is pending but ungranted are legal. The arbiter uses whatever is present in the IDLE cycle it grants.

## Timing
- Reset values, asserted asynchronously on rst_n low:
  - state = IDLE, last_gnt = fetch (so data wins the first tie);
  - counter = 0;
  - all outputs 0: if_ack, d_ack, mem_en, mem_we, busy, mem_addr, mem_wdata, if_rdata, d_rdata.
- Reset mid-access aborts the access: mem_en drops immediately and no ack is issued. Operation resumes in IDLE on the first edge after rst_n rises.
- If req is high in IDLE cycle T-1, then:
  - ISSUE is cycle T;
  - WAIT is cycles T+1..T+MEM_LAT;
  - ACK is cycle T+MEM_LAT+1;
  - IDLE is cycle T+MEM_LAT+2.
- Request-to-ack latency is MEM_LAT+2 cycles. Best throughput is one access per MEM_LAT+3 cycles.
- Read data is valid on if_rdata/d_rdata in the ACK cycle and after it.
- Fairness: with both ports continuously requesting, grants strictly alternate. No port waits more than one foreign access.
- if_ack and d_ack are never high in the same cycle.
- busy = (state != IDLE).

## Test plan
- Reset/idle: hold rst_n=0, then release with no requests -> all outputs 0, busy=0, mem_en never asserted.
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x0004, memory returns 0xDEADBEEF -> mem_en one cycle with mem_addr=0x0004 and mem_we=0; if_ack pulses 4 cycles after req seen; if_rdata=0xDEADBEEF.
- Store then load: d_we=1, d_addr=0x0010, d_wdata=0x12345678, then a load from 0x0010 -> first access has mem_we=1 and leaves d_rdata unchanged; second returns 0x12345678 on d_rdata with d_ack.
- Contention: if_req and d_req both held high for 4 accesses from reset -> grant order data, fetch, data, fetch; acks never overlap.
- Reset mid-access: drop rst_n during WAIT of a fetch -> mem_en=0 and no if_ack; after release with if_req high, the access replays from ISSUE with correct data.
- MEM_LAT=1 and MEM_LAT=15 builds: single read each -> ack at req+3 and req+17 respectively, with correct data.
